// File: rtl/mio_responder.sv
// Memory/IO responder for the CPU's MIO bus: word RAM plus a small IO file
// (gpio_out, cycle counter, gpio_in), answered after WAIT wait states.
// Ports:
//   clk, reset (async, active-low)
//   mem_r, mem_w, M_addr, data_out : request from the CPU
//   gpio_in                        : external input word
//   Data_in, MIO_ready             : response to the CPU
//   gpio_out                       : GPIO output register
module mio_responder #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] M_addr,
    input  logic [31:0] data_out,
    input  logic [31:0] gpio_in,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    output logic [31:0] gpio_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [3:0] WAIT_C = 4'(WAIT);
    localparam int         DEPTH  = 1 << ADDR_W;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] dat_q, dat_d;
    logic        rdy_q, rdy_d;
    logic [31:0] gpo_q, gpo_d;

    logic [31:0] mem_q [DEPTH];

    logic              req;
    logic              acc;
    logic [29:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_we;
    logic              is_io;
    logic [25:0]       io_off;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       rd_data;
    logic              ram_we;
    logic              unused_addr_bits;

    assign req = mem_r | mem_w;

    // With WAIT = 0 the access happens on the capture edge itself, so the
    // live bus values stand in for the not-yet-captured registers.
    assign acc_addr  = (state_q == S_IDLE) ? M_addr[31:2] : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? data_out : wdata_q;
    assign acc_we    = (state_q == S_IDLE) ? mem_w : we_q;

    assign is_io   = (acc_addr[29:26] == 4'hF);
    assign io_off  = acc_addr[25:0];
    assign ram_idx = acc_addr[ADDR_W-1:0];

    assign unused_addr_bits = ^M_addr[1:0];

    always_comb begin
        rd_data = 32'd0;
        if (is_io) begin
            case (io_off)
                26'd0:   rd_data = gpo_q;
                26'd1:   rd_data = cyc_q;
                26'd2:   rd_data = gpio_in;
                default: rd_data = 32'd0;
            endcase
        end else begin
            rd_data = mem_q[ram_idx];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        acc     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = M_addr[31:2];
                    wdata_d = data_out;
                    we_d    = mem_w;
                    cnt_d   = WAIT_C;
                    if (WAIT_C == 4'd0) begin
                        state_d = S_ACK;
                        acc     = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACK;
                    acc     = 1'b1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cyc_d = cyc_q + 32'd1;
        rdy_d = acc;
        dat_d = dat_q;
        gpo_d = gpo_q;
        if (acc) begin
            // Read-before-write: the old contents go back even on a write.
            dat_d = rd_data;
            if (acc_we && is_io && io_off == 26'd0) begin
                gpo_d = acc_wdata;
            end
        end
    end

    assign ram_we = acc & acc_we & ~is_io;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 30'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            cyc_q   <= 32'd0;
            dat_q   <= 32'd0;
            rdy_q   <= 1'b0;
            gpo_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            dat_q   <= dat_d;
            rdy_q   <= rdy_d;
            gpo_q   <= gpo_d;
        end
    end

    // RAM contents survive reset; a reset mid-access leaves the FSM in IDLE,
    // so ram_we stays low and the pending write is dropped.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= acc_wdata;
        end
    end

    assign Data_in   = dat_q;
    assign MIO_ready = rdy_q;
    assign gpio_out  = gpo_q;

endmodule
